// File: rtl/mmio_uart_ctrl_if.sv
// CPU data-memory port bundle: request from the core, registered read response back.
interface mmio_uart_ctrl_if;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] rd_data;
  logic        rd_valid;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  rd_data, rd_valid
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output rd_data, rd_valid
  );
endinterface

// File: rtl/mmio_uart_ctrl.sv
// Memory-mapped UART controller: RX/TX FIFOs, cycle and retired-instruction
// counters, and sticky W1C error flags in a 32-byte window at BASE.
module mmio_uart_ctrl #(
  parameter logic [31:0] BASE     = 32'h8000_0000,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned RX_DEPTH = 8,
  parameter int unsigned TX_DEPTH = 8,
  parameter int unsigned CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  mmio_uart_ctrl_if.slave   bus,
  input  logic              inst_retire,
  input  logic [DATA_W-1:0] uart_rx_data,
  input  logic              uart_rx_valid,
  output logic              uart_rx_ready,
  output logic [DATA_W-1:0] uart_tx_data,
  output logic              uart_tx_valid,
  input  logic              uart_tx_ready
);

  localparam int unsigned RX_AW = $clog2(RX_DEPTH);
  localparam int unsigned TX_AW = $clog2(TX_DEPTH);
  localparam logic [RX_AW:0]   RX_ONE  = 1;
  localparam logic [TX_AW:0]   TX_ONE  = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  typedef enum logic [2:0] {
    REG_CTRL    = 3'd0,
    REG_RX      = 3'd1,
    REG_TX      = 3'd2,
    REG_RSVD    = 3'd3,
    REG_CYCLE   = 3'd4,
    REG_INSTR   = 3'd5,
    REG_CNT_RST = 3'd6,
    REG_STATUS  = 3'd7
  } reg_off_e;

  logic              hit, rd_acc, wr_acc;
  reg_off_e          off;
  logic [31:0]       rd_next, rd_data_q;
  logic              rd_valid_q;
  logic [RX_AW:0]    rx_wptr, rx_rptr;
  logic [TX_AW:0]    tx_wptr, tx_rptr;
  logic [DATA_W-1:0] rx_mem [RX_DEPTH];
  logic [DATA_W-1:0] tx_mem [TX_DEPTH];
  logic              rx_full, rx_empty, tx_full, tx_empty;
  logic              rx_push, rx_pop, tx_push, tx_pop;
  logic [CNT_W-1:0]  cycle_cnt, instr_cnt;
  logic              cnt_clr;
  logic [1:0]        status, status_set, status_clr;
  logic              unused_bus;

  assign unused_bus = ^{bus.req_addr[1:0], bus.req_wdata};

  // Window match ignores the low 5 address bits; word offset picks the register.
  assign hit    = (bus.req_addr[31:5] == BASE[31:5]);
  assign off    = reg_off_e'(bus.req_addr[4:2]);
  assign rd_acc = bus.req_valid && !bus.req_we && hit;
  assign wr_acc = bus.req_valid &&  bus.req_we && hit;

  assign rx_empty = (rx_wptr == rx_rptr);
  assign rx_full  = (rx_wptr[RX_AW] != rx_rptr[RX_AW]) &&
                    (rx_wptr[RX_AW-1:0] == rx_rptr[RX_AW-1:0]);
  assign tx_empty = (tx_wptr == tx_rptr);
  assign tx_full  = (tx_wptr[TX_AW] != tx_rptr[TX_AW]) &&
                    (tx_wptr[TX_AW-1:0] == tx_rptr[TX_AW-1:0]);

  assign uart_rx_ready = !rx_full;
  assign uart_tx_valid = !tx_empty;
  assign uart_tx_data  = tx_mem[tx_rptr[TX_AW-1:0]];

  assign rx_push = uart_rx_valid && !rx_full;
  assign rx_pop  = rd_acc && (off == REG_RX) && !rx_empty;
  assign tx_push = wr_acc && (off == REG_TX) && !tx_full;
  assign tx_pop  = uart_tx_ready && !tx_empty;
  assign cnt_clr = wr_acc && (off == REG_CNT_RST);

  // Full/empty are pre-edge, so a push into a full FIFO is dropped even if it drains.
  assign status_set = {rd_acc && (off == REG_RX) && rx_empty,
                       wr_acc && (off == REG_TX) && tx_full};
  assign status_clr = (wr_acc && (off == REG_STATUS)) ? bus.req_wdata[1:0] : '0;

  always_comb begin
    rd_next = '0;
    case (off)
      REG_CTRL:   rd_next = {30'b0, !rx_empty, !tx_full};
      REG_RX:     rd_next = rx_empty ? '0 : 32'(rx_mem[rx_rptr[RX_AW-1:0]]);
      REG_CYCLE:  rd_next = 32'(cycle_cnt);
      REG_INSTR:  rd_next = 32'(instr_cnt);
      REG_STATUS: rd_next = {30'b0, status};
      default:    rd_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wptr[RX_AW-1:0]] <= uart_rx_data;
    if (tx_push) tx_mem[tx_wptr[TX_AW-1:0]] <= bus.req_wdata[DATA_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wptr    <= '0;
      rx_rptr    <= '0;
      tx_wptr    <= '0;
      tx_rptr    <= '0;
      cycle_cnt  <= '0;
      instr_cnt  <= '0;
      status     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      if (rx_push) rx_wptr <= rx_wptr + RX_ONE;
      if (rx_pop)  rx_rptr <= rx_rptr + RX_ONE;
      if (tx_push) tx_wptr <= tx_wptr + TX_ONE;
      if (tx_pop)  tx_rptr <= tx_rptr + TX_ONE;
      cycle_cnt <= cnt_clr ? '0 : cycle_cnt + CNT_ONE;
      if (cnt_clr)          instr_cnt <= '0;
      else if (inst_retire) instr_cnt <= instr_cnt + CNT_ONE;
      status     <= (status & ~status_clr) | status_set;
      rd_valid_q <= rd_acc;
      if (rd_acc) rd_data_q <= rd_next;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;

endmodule

// File: tb/tb_mmio_uart_ctrl.sv
// Scoreboard bench for mmio_uart_ctrl: reads and TX drains are checked by
// negedge monitors against queues filled when stimulus is issued.
module tb_mmio_uart_ctrl;
  localparam logic [31:0] BASE = 32'h8000_0000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       inst_retire = 1'b0;
  logic [7:0] uart_rx_data = '0;
  logic       uart_rx_valid = 1'b0;
  logic       uart_rx_ready;
  logic [7:0] uart_tx_data;
  logic       uart_tx_valid;
  logic       uart_tx_ready = 1'b0;

  always #5 clk = ~clk;

  mmio_uart_ctrl_if bus ();

  mmio_uart_ctrl #(
    .BASE(BASE), .DATA_W(8), .RX_DEPTH(8), .TX_DEPTH(8), .CNT_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .inst_retire(inst_retire),
    .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid),
    .uart_rx_ready(uart_rx_ready), .uart_tx_data(uart_tx_data),
    .uart_tx_valid(uart_tx_valid), .uart_tx_ready(uart_tx_ready)
  );

  int total = 0;
  int bad = 0;
  logic [31:0] rd_exp_q[$];
  logic [7:0]  tx_exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.rd_valid) begin
      if (rd_exp_q.size() == 0) check("rd_spurious", 32'(bus.rd_valid), 32'h0);
      else check("rd_data", bus.rd_data, rd_exp_q.pop_front());
    end
    if (rst_n && uart_tx_valid && uart_tx_ready) begin
      if (tx_exp_q.size() == 0) check("tx_spurious", 32'(uart_tx_valid), 32'h0);
      else check("tx_data", 32'(uart_tx_data), 32'(tx_exp_q.pop_front()));
    end
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic rd_addr(input logic [31:0] addr, input bit resp, input logic [31:0] exp);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = addr;
    if (resp) rd_exp_q.push_back(exp);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic rd(input logic [7:0] off, input logic [31:0] exp);
    rd_addr(BASE + 32'(off), 1'b1, exp);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = addr;
    bus.req_wdata = data;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
  endtask

  task automatic rx_push(input logic [7:0] d);
    uart_rx_valid = 1'b1;
    uart_rx_data  = d;
    @(posedge clk); #1;
    uart_rx_valid = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rd_valid", 32'(bus.rd_valid), 32'h0);
    check("rst_rd_data", bus.rd_data, 32'h0);
    check("rst_rx_ready", 32'(uart_rx_ready), 32'h1);
    check("rst_tx_valid", 32'(uart_tx_valid), 32'h0);
    rst_n = 1'b1;
    rd(8'h00, 32'h1);

    // TX fill with the UART stalled; ninth write is dropped
    for (int i = 0; i < 8; i++) begin
      wr(BASE + 32'h08, 32'h41 + 32'(i));
      tx_exp_q.push_back(8'h41 + 8'(i));
    end
    check("tx_valid_fill", 32'(uart_tx_valid), 32'h1);
    check("tx_head", 32'(uart_tx_data), 32'h41);
    rd(8'h00, 32'h0);
    wr(BASE + 32'h08, 32'h49);
    rd(8'h1C, 32'h1);

    // RX path while TX is still full
    rx_push(8'h55);
    rx_push(8'hAA);
    rd(8'h00, 32'h2);
    rd(8'h04, 32'h55);
    rd(8'h04, 32'hAA);
    rd(8'h04, 32'h0);
    rd(8'h1C, 32'h3);
    wr(BASE + 32'h1C, 32'h2);
    rd(8'h1C, 32'h1);

    // Drain TX one per cycle
    uart_tx_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("tx_drained", 32'(uart_tx_valid), 32'h0);
    uart_tx_ready = 1'b0;
    wr(BASE + 32'h1C, 32'h1);
    rd(8'h1C, 32'h0);
    rd(8'h00, 32'h1);

    // Steady occupancy of one through the pointer wrap
    rx_push(8'h10);
    for (int i = 0; i < 20; i++) begin
      uart_rx_valid = 1'b1;
      uart_rx_data  = 8'h11 + 8'(i);
      rd(8'h04, 32'h10 + 32'(i));
    end
    uart_rx_valid = 1'b0;
    rd(8'h00, 32'h3);
    rd(8'h04, 32'h24);
    rd(8'h00, 32'h1);

    // Counters (CNT_W = 4): clear beats a same-cycle retire
    inst_retire = 1'b1;
    wr(BASE + 32'h18, 32'hDEAD);
    inst_retire = 1'b0;
    rd(8'h10, 32'd0);
    rd(8'h10, 32'd1);
    for (int i = 0; i < 10; i++) begin
      inst_retire = (i % 2 == 0);
      idle();
    end
    inst_retire = 1'b0;
    rd(8'h14, 32'd5);
    rd(8'h10, 32'd13);
    idle();
    rd(8'h10, 32'd15);
    rd(8'h10, 32'd0);

    // Address decode and wrong-direction accesses
    rx_push(8'h77);
    rd_addr(BASE + 32'h24, 1'b0, 32'h0);
    rd_addr(BASE - 32'h4, 1'b0, 32'h0);
    rd(8'h00, 32'h3);
    wr(BASE + 32'h28, 32'h99);
    check("oow_tx_write", 32'(uart_tx_valid), 32'h0);
    wr(BASE + 32'h00, 32'hFF);
    wr(BASE + 32'h3C, 32'h3);
    rd(8'h0C, 32'h0);
    rd(8'h08, 32'h0);
    rd(8'h18, 32'h0);
    rd(8'h04, 32'h77);
    rd(8'h00, 32'h1);
    idle();
    check("rd_hold_data", bus.rd_data, 32'h1);
    check("rd_hold_valid", 32'(bus.rd_valid), 32'h0);

    // Asynchronous reset mid-cycle with a read response pending
    wr(BASE + 32'h08, 32'h5A);
    rx_push(8'h33);
    check("pre_rst_tx_valid", 32'(uart_tx_valid), 32'h1);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = BASE;
    @(posedge clk);
    bus.req_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_rd_valid", 32'(bus.rd_valid), 32'h0);
    check("arst_rd_data", bus.rd_data, 32'h0);
    check("arst_tx_valid", 32'(uart_tx_valid), 32'h0);
    check("arst_rx_ready", 32'(uart_rx_ready), 32'h1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rd(8'h00, 32'h1);
    rd(8'h1C, 32'h0);

    idle();
    idle();
    check("rd_queue_left", 32'(rd_exp_q.size()), 32'h0);
    check("tx_queue_left", 32'(tx_exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mmio_uart_ctrl.md
# mmio_uart_ctrl

Parametrised memory-mapped I/O controller between the CPU data-memory port and the UART. It provides configurable-depth RX and TX FIFOs in place of single-entry data handshakes, plus a cycle counter, a retired-instruction counter and sticky error flags. All registers sit in a decoded window at `BASE`; CPU accesses outside the window are ignored.

## Interface

- `BASE`, 32'h8000_0000: base address of the register window; the window is 32 bytes, word-aligned.
- `DATA_W`, 8: UART character width; 1..32.
- `RX_DEPTH`, 8: RX FIFO entries; power of two, ≥2.
- `TX_DEPTH`, 8: TX FIFO entries; power of two, ≥2.
- `CNT_W`, 32: counter width; 1..32, zero-extended on read.

Ports:

- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: CPU access this cycle.
- `req_we` in 1: 1 = write, 0 = read.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: write data.
- `rd_data` out 32: registered read data.
- `rd_valid` out 1: `rd_data` holds a window read response.
- `inst_retire` in 1: one instruction retired this cycle.
- `uart_rx_data` in DATA_W: received character.
- `uart_rx_valid` in 1: `uart_rx_data` is valid.
- `uart_rx_ready` out 1: equals `!rx_full` (combinational).
- `uart_tx_data` out DATA_W: TX FIFO head.
- `uart_tx_valid` out 1: equals `!tx_empty` (combinational).
- `uart_tx_ready` in 1: UART accepts `uart_tx_data`.

## Operation

Register map (offset from `BASE`):

- **0x00 CTRL (R):** bit0 = `!tx_full`, bit1 = `!rx_empty`; all other bits 0.
- **0x04 RX (R):** returns the RX head, zero-extended, and pops it.
  - If the FIFO is empty, returns 0 and does not pop.
- **0x08 TX (W):** pushes `req_wdata[DATA_W-1:0]`.
  - If the FIFO is full, the write is dropped and `tx_drop` is set.
- **0x10 CYCLE (R):** cycle counter.
- **0x14 INSTR (R):** retired-instruction counter.
- **0x18 CNT_RST (W):** any write clears both counters; the data value is ignored.
- **0x1C STATUS (R/W1C):**
  - bit0 `tx_drop`.
  - bit1 `rx_underflow`: set by a read of RX while the FIFO is empty.
  - Writing 1 to a bit clears it.
- Other in-window offsets: reads return 0 (with `rd_valid` = 1); writes are ignored.
- Wrong-direction accesses (read of a W register, write of an R register) behave like the unmapped case.

FIFOs:

- Implementation: circular buffer, read/write pointers of log2(DEPTH)+1 bits.
  - Full: pointers differ only in the MSB.
  - Empty: pointers are equal.
  - Pointers wrap modulo 2·DEPTH.
- RX push: `uart_rx_valid && uart_rx_ready`. RX pop: CPU read of 0x04 while not empty.
- TX push: CPU write of 0x08 while not full. TX pop: `uart_tx_valid && uart_tx_ready`.
- Simultaneous push and pop on the same FIFO:
  - Both take effect; occupancy is unchanged.
  - When full, a TX push with a same-cycle UART pop is still dropped, because full is evaluated pre-edge. The same applies to RX: `uart_rx_ready` is 0 when full.
  - When empty, a pop is not performed even if a push occurs in the same cycle.

Counters:

- CYCLE increments every cycle. INSTR increments when `inst_retire` = 1.
- Both wrap at 2^CNT_W to 0.
- A CNT_RST write has priority over an increment in the same cycle.
- STATUS: a set and a W1C clear of the same bit in the same cycle leaves the bit set.

## Timing

- Reset (`rst_n` low, asynchronous):
  - Both FIFOs empty; counters = 0; STATUS = 0; `rd_data` = 0; `rd_valid` = 0.
  - Resulting outputs: `uart_rx_ready` = 1, `uart_tx_valid` = 0.
  - Reset mid-transaction discards FIFO contents and any pending read response.
- Read latency is 1 cycle:
  - A read accepted at edge t presents `rd_data`/`rd_valid` in the cycle after t.
  - The returned value is the pre-edge state: CTRL and counters as sampled in the request cycle.
- `rd_valid` is high for exactly one cycle per in-window read; `rd_data` holds its value otherwise.
- Side effects (pops, pushes, clears, counter reset) take effect at the edge ending the request cycle.
- A TX push at edge t makes `uart_tx_valid` = 1 in cycle t+1 if the FIFO was empty.
- An RX push at edge t is visible in CTRL bit1 on a read issued in cycle t+1.
- CNT_RST write at edge t: CYCLE reads 0 if sampled in cycle t+1, and 1 in cycle t+2.

## Test plan

- **Reset:** assert `rst_n` = 0 asynchronously mid-cycle → all outputs reach reset values before the next edge; a CTRL read afterwards returns 0x1.
- **TX fill:** with `TX_DEPTH` = 8 and `uart_tx_ready` = 0, write 0x41..0x49 (9 writes) → CTRL bit0 = 0 after the 8th write; 9th dropped; STATUS = 0x1; raising `uart_tx_ready` drains 0x41..0x48 in order, one per cycle.
- **RX path:** push 0x55, 0xAA from the UART → CTRL reads 0x2; RX reads return 0x55, then 0xAA; a third RX read returns 0 and sets STATUS bit1; W1C of 0x2 clears it.
- **Wrap and simultaneity:** 20 push/pop pairs through the RX FIFO with same-cycle push and pop when 1 entry is occupied → occupancy stays 1; data order preserved across the pointer wrap.
- **Counters:** `inst_retire` high every other cycle for 10 cycles → INSTR = 5; CNT_RST write in a cycle with `inst_retire` = 1 → CYCLE reads 0 at t+1; with `CNT_W` = 4, CYCLE wraps 15 → 0.
- **Address decode:** read of `BASE`+0x20 → `rd_valid` = 0, no state change; read of 0x0C → 0 with `rd_valid` = 1.
